spi_rx_ml: RTL and testbench

Parametrised multi-lane SPI receive engine. It is the next-generation receive path for the APB SPI master. It deserialises standard (1-lane), dual (2-lane) or quad (4-lane) input data, MSB- or LSB-first, into DATA_W-bit words. Completed words are pushed into a 2-entry output FIFO with a valid/ready interface. When the FIFO cannot accept a word, the engine raises a stall request so the SPI clock generator pauses SCK.

---
 rtl/spi_pkg.sv | 26 ++
 rtl/spi_rx_ml_if.sv | 11 +
 rtl/spi_rx_fifo2.sv | 54 +++++
 rtl/spi_rx_ml.sv | 171 +++++++++++++++++
 tb/tb_spi_rx_ml.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: lane-mode encodings, receive FSM states and the
// mode-to-lane-count helper used by both the receive and transmit paths.
package spi_pkg;

  localparam logic [1:0] SPI_MODE_STD  = 2'd0;
  localparam logic [1:0] SPI_MODE_DUAL = 2'd1;
  localparam logic [1:0] SPI_MODE_QUAD = 2'd2;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_RECV  = 2'd1,
    RX_STALL = 2'd2
  } rx_state_e;

  // Number of data lanes sampled per SCK edge; the reserved code falls back to 1.
  function automatic logic [2:0] spi_lanes(input logic [1:0] mode);
    logic [2:0] lanes;
    case (mode)
      SPI_MODE_DUAL: lanes = 3'd2;
      SPI_MODE_QUAD: lanes = 3'd4;
      default:       lanes = 3'd1;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/spi_rx_ml_if.sv
// Receive word stream: FIFO head word with valid/ready handshake.
interface spi_rx_ml_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] rx_data_o;
  logic              rx_data_vld_o;
  logic              rx_data_rdy_i;

  modport master (output rx_data_o, output rx_data_vld_o, input rx_data_rdy_i);
  modport slave  (input rx_data_o, input rx_data_vld_o, output rx_data_rdy_i);
endinterface

// File: rtl/spi_rx_fifo2.sv
// Two-entry register FIFO. A push into a full FIFO is accepted only when a
// pop happens in the same cycle, so occupancy then stays at two.
module spi_rx_fifo2 #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_full,
  output logic              o_empty
);

  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_cnt;
  logic              w_do_push;
  logic              w_do_pop;

  assign w_do_pop  = i_pop && (r_cnt != 2'd0);
  assign w_do_push = i_push && ((r_cnt != 2'd2) || w_do_pop);

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wptr] <= i_data;
        r_wptr        <= ~r_wptr;
      end
      if (w_do_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign o_data  = r_mem[r_rptr];
  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);

endmodule

// File: rtl/spi_rx_ml.sv
// Multi-lane SPI receive engine: deserialises 1/2/4-lane data, MSB- or
// LSB-first, into DATA_W-bit words and queues them in a 2-entry FIFO.
// When the FIFO is full the completed word is held and SCK is stalled.
module spi_rx_ml
  import spi_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             en_i,
  input  logic             rx_edge_i,
  input  logic [3:0]       sdi_i,
  input  logic [1:0]       mode_i,
  input  logic             lsb_first_i,
  input  logic [LEN_W-1:0] rx_len_i,
  input  logic             rx_len_upd_i,
  spi_rx_ml_if.master      rx_if,
  output logic             rx_done_o,
  output logic             rx_stall_o,
  output logic             rx_busy_o,
  output logic             rx_ovf_o
);

  localparam int CW = $clog2(DATA_W + 1);

  rx_state_e         r_state, w_state_nxt;
  logic [LEN_W-1:0]  r_len_q, r_len_tgt, r_bit_cnt;
  logic [CW-1:0]     r_wcnt;
  logic [DATA_W-1:0] r_shift, r_hold;
  logic [1:0]        r_mode;
  logic              r_lsb, r_hold_last, r_done, r_ovf;

  logic [2:0]        w_lanes;
  logic [LEN_W:0]    w_bits_nxt;
  logic [CW-1:0]     w_wcnt_nxt, w_rjust;
  logic [DATA_W-1:0] w_shift_nxt, w_word, w_push_data;
  logic              w_start, w_edge_acc, w_last, w_word_done, w_new_word;
  logic              w_full, w_empty, w_pop, w_space, w_stall_push, w_push;

  assign w_lanes      = spi_lanes(r_mode);
  assign w_start      = (r_state == RX_IDLE) && en_i && (r_len_q != '0);
  assign w_edge_acc   = (r_state == RX_RECV) && rx_edge_i;
  assign w_bits_nxt   = {1'b0, r_bit_cnt} + (LEN_W + 1)'(w_lanes);
  assign w_last       = (w_bits_nxt >= {1'b0, r_len_tgt});
  assign w_wcnt_nxt   = r_wcnt + CW'(w_lanes);
  assign w_rjust      = CW'(DATA_W) - w_wcnt_nxt;
  assign w_word_done  = (w_wcnt_nxt == CW'(DATA_W)) || w_last;
  assign w_new_word   = w_edge_acc && w_word_done;
  assign w_pop        = !w_empty && rx_if.rx_data_rdy_i;
  assign w_space      = !w_full || w_pop;
  assign w_stall_push = (r_state == RX_STALL) && w_pop;
  assign w_push       = (w_new_word && w_space) || w_stall_push;

  // Shift the sampled lanes in; LSB-first fills from the top and shifts right.
  always_comb begin
    w_shift_nxt = r_shift;
    case (r_mode)
      SPI_MODE_DUAL: begin
        if (r_lsb) w_shift_nxt = {sdi_i[1:0], r_shift[DATA_W-1:2]};
        else       w_shift_nxt = {r_shift[DATA_W-3:0], sdi_i[1:0]};
      end
      SPI_MODE_QUAD: begin
        if (r_lsb) w_shift_nxt = {sdi_i[3:0], r_shift[DATA_W-1:4]};
        else       w_shift_nxt = {r_shift[DATA_W-5:0], sdi_i[3:0]};
      end
      default: begin
        if (r_lsb) w_shift_nxt = {sdi_i[0], r_shift[DATA_W-1:1]};
        else       w_shift_nxt = {r_shift[DATA_W-2:0], sdi_i[0]};
      end
    endcase
  end

  // Form the completed word (right-justify partial LSB-first words) and pick the FIFO input.
  always_comb begin
    w_word      = w_shift_nxt;
    w_push_data = w_word;
    if (r_lsb) w_word = w_shift_nxt >> w_rjust;
    else       w_word = w_shift_nxt;
    if (r_state == RX_STALL) w_push_data = r_hold;
    else                     w_push_data = w_word;
  end

  // FSM state register.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= RX_IDLE;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RX_IDLE: begin
        if (w_start) w_state_nxt = RX_RECV;
        else         w_state_nxt = RX_IDLE;
      end
      RX_RECV: begin
        if (w_new_word && !w_space)     w_state_nxt = RX_STALL;
        else if (w_new_word && w_last)  w_state_nxt = RX_IDLE;
        else                            w_state_nxt = RX_RECV;
      end
      RX_STALL: begin
        if (w_pop) w_state_nxt = r_hold_last ? RX_IDLE : RX_RECV;
        else       w_state_nxt = RX_STALL;
      end
      default: w_state_nxt = RX_IDLE;
    endcase
  end

  // Datapath: length register, per-transfer settings, counters, shifter, flags.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_len_q     <= '0;
      r_len_tgt   <= '0;
      r_bit_cnt   <= '0;
      r_wcnt      <= '0;
      r_shift     <= '0;
      r_hold      <= '0;
      r_mode      <= SPI_MODE_STD;
      r_lsb       <= 1'b0;
      r_hold_last <= 1'b0;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      if (rx_len_upd_i) r_len_q <= rx_len_i;
      if (w_start) begin
        r_mode    <= mode_i;
        r_lsb     <= lsb_first_i;
        r_len_tgt <= r_len_q;
        r_bit_cnt <= '0;
        r_wcnt    <= '0;
        r_shift   <= '0;
        r_ovf     <= 1'b0;
      end else if (w_edge_acc) begin
        r_bit_cnt <= w_bits_nxt[LEN_W-1:0];
        if (w_word_done) begin
          r_wcnt      <= '0;
          r_shift     <= '0;
          r_hold      <= w_word;
          r_hold_last <= w_last;
        end else begin
          r_wcnt  <= w_wcnt_nxt;
          r_shift <= w_shift_nxt;
        end
      end else if ((r_state == RX_STALL) && rx_edge_i) begin
        r_ovf <= 1'b1;
      end
      r_done <= (w_new_word && w_space && w_last) || (w_stall_push && r_hold_last);
    end
  end

  spi_rx_fifo2 #(.DATA_W(DATA_W)) u_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_push  (w_push),
    .i_data  (w_push_data),
    .i_pop   (w_pop),
    .o_data  (rx_if.rx_data_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign rx_if.rx_data_vld_o = !w_empty;
  assign rx_done_o           = r_done;
  assign rx_stall_o          = (r_state == RX_STALL);
  assign rx_busy_o           = (r_state != RX_IDLE);
  assign rx_ovf_o            = r_ovf;

endmodule

// File: tb/tb_spi_rx_ml.sv
// Self-checking bench for spi_rx_ml: directed cases plus randomized
// transfers checked against a bit-position reference model and scoreboard.
module tb_spi_rx_ml;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic        en_i = 1'b0;
  logic        rx_edge_i = 1'b0;
  logic [3:0]  sdi_i = 4'd0;
  logic [1:0]  mode_i = 2'd0;
  logic        lsb_first_i = 1'b0;
  logic [15:0] rx_len_i = 16'd0;
  logic        rx_len_upd_i = 1'b0;
  logic        rx_done_o, rx_stall_o, rx_busy_o, rx_ovf_o;

  spi_rx_ml_if #(.DATA_W(32)) rx_if ();

  spi_rx_ml #(.DATA_W(32), .LEN_W(16)) dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .en_i         (en_i),
    .rx_edge_i    (rx_edge_i),
    .sdi_i        (sdi_i),
    .mode_i       (mode_i),
    .lsb_first_i  (lsb_first_i),
    .rx_len_i     (rx_len_i),
    .rx_len_upd_i (rx_len_upd_i),
    .rx_if        (rx_if),
    .rx_done_o    (rx_done_o),
    .rx_stall_o   (rx_stall_o),
    .rx_busy_o    (rx_busy_o),
    .rx_ovf_o     (rx_ovf_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_tests = 0;
  int          n_fail = 0;
  int          done_cnt = 0;
  int          pop_cnt = 0;
  bit          stall_seen = 1'b0;
  int          rdy_mode = 2;   // 0 random, 1 never ready, 2 always ready
  logic [31:0] exp_q[$];
  logic [3:0]  edata[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Consumer: drives ready just after each rising edge.
  initial begin
    rx_if.rx_data_rdy_i = 1'b0;
    forever begin
      @(posedge clk_i); #1;
      case (rdy_mode)
        0:       rx_if.rx_data_rdy_i = ($urandom_range(0, 3) != 0);
        1:       rx_if.rx_data_rdy_i = 1'b0;
        default: rx_if.rx_data_rdy_i = 1'b1;
      endcase
    end
  end

  // Monitor on the falling edge: scoreboard pops, count done pulses, note stalls.
  always @(negedge clk_i) begin
    if (rstn_i && rx_if.rx_data_vld_o && rx_if.rx_data_rdy_i) begin
      pop_cnt++;
      if (exp_q.size() == 0) chk("unexpected_word", {32'd0, rx_if.rx_data_o}, 64'd0);
      else                   chk("word", {32'd0, rx_if.rx_data_o}, {32'd0, exp_q.pop_front()});
    end
    if (rx_done_o)  done_cnt++;
    if (rx_stall_o) stall_seen = 1'b1;
  end

  // Reference model: place each captured bit at its word position from the bit-order rules.
  function automatic void model(input int lanes, input bit lsb, input int len);
    int n_edges = (len + lanes - 1) / lanes;
    int epw = 32 / lanes;
    int e = 0;
    while (e < n_edges) begin
      int n;
      logic [31:0] w;
      n = (n_edges - e < epw) ? (n_edges - e) : epw;
      w = 32'd0;
      for (int k = 0; k < n; k++)
        for (int l = 0; l < lanes; l++)
          w[lsb ? (k * lanes + l) : ((n - 1 - k) * lanes + l)] = edata[e + k][l];
      exp_q.push_back(w);
      e += n;
    end
  endfunction

  // Build edge data that carries value v in the given bit order.
  function automatic void fill_val(input int lanes, input bit lsb, input int len, input logic [63:0] v);
    int n_edges = (len + lanes - 1) / lanes;
    logic [63:0] m = (64'd1 << lanes) - 64'd1;
    logic [63:0] d;
    edata.delete();
    for (int k = 0; k < n_edges; k++) begin
      d = lsb ? ((v >> (k * lanes)) & m) : ((v >> ((n_edges - 1 - k) * lanes)) & m);
      edata.push_back(d[3:0]);
    end
  endfunction

  function automatic void fill_rand(input int lanes, input int len);
    edata.delete();
    for (int k = 0; k < (len + lanes - 1) / lanes; k++) edata.push_back(4'($urandom));
  endfunction

  task automatic load_len(input int len);
    rx_len_i = 16'(len); rx_len_upd_i = 1'b1;
    @(posedge clk_i); #1;
    rx_len_upd_i = 1'b0;
  endtask

  task automatic start(input logic [1:0] mode, input bit lsb);
    mode_i = mode; lsb_first_i = lsb; en_i = 1'b1;
    @(posedge clk_i); #1;
    en_i = 1'b0; mode_i = 2'($urandom); lsb_first_i = 1'($urandom);
    chk("busy_after_start", {63'd0, rx_busy_o}, 64'd1);
  endtask

  task automatic send_edge(input logic [3:0] d, input bit frc, input int gap);
    int t = 0;
    while (!frc && rx_stall_o && t < 1000) begin @(posedge clk_i); #1; t++; end
    if (t >= 1000) chk("stall_release_timeout", 64'd1, 64'd0);
    rx_edge_i = 1'b1; sdi_i = d;
    @(posedge clk_i); #1;
    rx_edge_i = 1'b0; sdi_i = 4'($urandom);
    repeat (gap) begin @(posedge clk_i); #1; end
  endtask

  task automatic send_range(input int from, input int to, input bit rgap);
    for (int i = from; i < to; i++) send_edge(edata[i], 1'b0, rgap ? $urandom_range(0, 2) : 0);
  endtask

  task automatic drain(input string tag);
    int t = 0;
    while ((exp_q.size() != 0 || rx_busy_o) && t < 3000) begin @(posedge clk_i); #1; t++; end
    if (t >= 3000) chk({tag, "_drain_timeout"}, 64'd1, 64'd0);
    repeat (2) begin @(posedge clk_i); #1; end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_data"},  {32'd0, rx_if.rx_data_o}, 64'd0);
    chk({tag, "_vld"},   {63'd0, rx_if.rx_data_vld_o}, 64'd0);
    chk({tag, "_done"},  {63'd0, rx_done_o}, 64'd0);
    chk({tag, "_stall"}, {63'd0, rx_stall_o}, 64'd0);
    chk({tag, "_busy"},  {63'd0, rx_busy_o}, 64'd0);
    chk({tag, "_ovf"},   {63'd0, rx_ovf_o}, 64'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk_reset_outputs("reset");
    rstn_i = 1'b1;
    @(posedge clk_i); #1;

    // Standard MSB-first, 32 bits.
    rdy_mode = 2; done_cnt = 0;
    load_len(32); fill_val(1, 1'b0, 32, 64'hA5C3_0F96);
    exp_q.push_back(32'hA5C3_0F96);
    start(2'd0, 1'b0);
    send_range(0, 32, 1'b0);
    chk("std_done_with_push", {63'd0, rx_done_o}, 64'd1);
    chk("std_vld_with_push", {63'd0, rx_if.rx_data_vld_o}, 64'd1);
    chk("std_idle_after_last", {63'd0, rx_busy_o}, 64'd0);
    drain("std");
    chk("std_done_count", 64'(done_cnt), 64'd1);

    // Quad LSB-first, 64 bits, two words, no stall.
    done_cnt = 0; stall_seen = 1'b0;
    load_len(64); fill_val(4, 1'b1, 64, 64'h9ABC_DEF0_1234_5678);
    exp_q.push_back(32'h1234_5678); exp_q.push_back(32'h9ABC_DEF0);
    start(2'd2, 1'b1);
    send_range(0, 16, 1'b0);
    send_range(16, 32, 1'b0);
    drain("quad");
    chk("quad_no_stall", {63'd0, stall_seen}, 64'd0);
    chk("quad_done_count", 64'(done_cnt), 64'd1);

    // Dual MSB-first, 20-bit partial word.
    done_cnt = 0;
    load_len(20); fill_val(2, 1'b0, 20, 64'hA_BCDE);
    exp_q.push_back(32'h000A_BCDE);
    start(2'd1, 1'b0);
    send_range(0, 10, 1'b0);
    drain("dual");
    chk("dual_done_count", 64'(done_cnt), 64'd1);

    // Standard 128 bits with consumer blocked: stall, overflow, then drain.
    done_cnt = 0; pop_cnt = 0; rdy_mode = 1;
    load_len(128); fill_rand(1, 128); model(1, 1'b0, 128);
    start(2'd0, 1'b0);
    send_range(0, 96, 1'b0);
    chk("stall_when_full", {63'd0, rx_stall_o}, 64'd1);
    chk("no_ovf_before_edge", {63'd0, rx_ovf_o}, 64'd0);
    send_edge(4'hF, 1'b1, 0);
    chk("ovf_on_stalled_edge", {63'd0, rx_ovf_o}, 64'd1);
    chk("still_stalled", {63'd0, rx_stall_o}, 64'd1);
    rdy_mode = 2;
    send_range(96, 128, 1'b0);
    drain("stall");
    chk("stall_released", {63'd0, rx_stall_o}, 64'd0);
    chk("stall_word_count", 64'(pop_cnt), 64'd4);
    chk("stall_done_count", 64'(done_cnt), 64'd1);

    // Zero length: no start. Then a length reload during a transfer.
    done_cnt = 0;
    load_len(0);
    en_i = 1'b1; @(posedge clk_i); #1; en_i = 1'b0;
    chk("len0_stays_idle", {63'd0, rx_busy_o}, 64'd0);
    repeat (3) begin @(posedge clk_i); #1; end
    chk("len0_no_done", 64'(done_cnt), 64'd0);
    load_len(16); fill_val(1, 1'b0, 16, 64'hBEEF);
    exp_q.push_back(32'h0000_BEEF);
    start(2'd0, 1'b0);
    chk("ovf_cleared_on_start", {63'd0, rx_ovf_o}, 64'd0);
    send_range(0, 3, 1'b0);
    load_len(8);
    send_range(3, 16, 1'b0);
    drain("reload");
    chk("reload_done_count", 64'(done_cnt), 64'd1);
    done_cnt = 0;
    fill_val(1, 1'b0, 8, 64'h5A);
    exp_q.push_back(32'h0000_005A);
    start(2'd0, 1'b0);
    send_range(0, 8, 1'b0);
    drain("len8");
    chk("len8_done_count", 64'(done_cnt), 64'd1);

    // Reset in the middle of a quad transfer, then a clean transfer.
    load_len(64); fill_rand(4, 64);
    start(2'd2, 1'b0);
    send_range(0, 4, 1'b0);
    rx_edge_i = 1'b1; sdi_i = 4'h7;
    #2; rstn_i = 1'b0; #1;
    rx_edge_i = 1'b0;
    chk_reset_outputs("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #1; rstn_i = 1'b1;
    en_i = 1'b1; @(posedge clk_i); #1; en_i = 1'b0;
    chk("len_cleared_by_reset", {63'd0, rx_busy_o}, 64'd0);
    done_cnt = 0;
    load_len(32); fill_rand(4, 32); model(4, 1'b0, 32);
    start(2'd2, 1'b0);
    send_range(0, 8, 1'b0);
    drain("post_reset");
    chk("post_reset_done_count", 64'(done_cnt), 64'd1);

    // Randomized transfers with random gaps and random consumer back-pressure.
    rdy_mode = 0;
    for (int it = 0; it < 24; it++) begin
      int mode = $urandom_range(0, 3);
      int lanes = (mode == 1) ? 2 : (mode == 2) ? 4 : 1;
      bit lsb = 1'($urandom);
      int len = $urandom_range(1, 96);
      done_cnt = 0;
      load_len(len); fill_rand(lanes, len); model(lanes, lsb, len);
      start(2'(mode), lsb);
      send_range(0, edata.size(), 1'b1);
      drain("rand");
      chk("rand_done_count", 64'(done_cnt), 64'd1);
      chk("rand_no_ovf", {63'd0, rx_ovf_o}, 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
